i2c_bus_arbiter: RTL and testbench
==================================

Name: i2c_bus_arbiter

Overview:
Shares one open-drain I2C bus (the camera/VCM bus) between two masters. Requester 0 is the Nios I2C core; requester 1 is the auto-focus VCM writer. The block arbitrates round-robin and only grants once the bus has been idle for a set time. It can also restrict VCM transactions to vertical blanking, and a watchdog forces release from a hung master. It sits between the two masters' open-drain enables and the shared pads.

Parameters:
BUS_IDLE_CYC, 8, consecutive cycles with SCL and SDA both high needed before any grant
TIMEOUT_CYC, 100000, maximum grant length in cycles; 0 disables the watchdog
WDOG_W, 24, watchdog counter width; TIMEOUT_CYC must fit in it
GATE_VBLANK, 1, 1 = requester 1 is eligible only while synchronised FVAL is low

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
req  in  2  per-requester bus request, level, held for the whole transaction
done  in  2  per-requester end-of-transaction pulse, 1 cycle
gnt  out  2  one-hot grant, registered
scl_oe_i  in  2  per-requester SCL pull-low enable
sda_oe_i  in  2  per-requester SDA pull-low enable
scl_oe  out  1  pad SCL pull-low enable
sda_oe  out  1  pad SDA pull-low enable
scl_in  in  1  pad SCL level, asynchronous
sda_in  in  1  pad SDA level, asynchronous
fval  in  1  camera frame-valid, asynchronous
timeout_clr  in  1  clears timeout_flag
timeout_flag  out  2  sticky watchdog-fired flag, one bit per requester
busy  out  1  OR of gnt

Behaviour:
- Synchronisation: scl_in, sda_in and fval each pass through a 2-flop synchroniser. All decisions use the synchronised values.
- Reset state: gnt=00, busy=0, timeout_flag=00, state BUS_CHK, idle counter 0, watchdog 0, round-robin pointer = requester 0.
- Pad outputs: scl_oe = scl_oe_i[n] when gnt[n], else 0. sda_oe is muxed the same way.
  - The mux is combinational, gated by the gnt register.
  - An async reset therefore releases both pads immediately.
- BUS_CHK:
  - The idle counter increments while SCL and SDA are both high; it clears to 0 in any cycle where either is low.
  - When the counter equals BUS_IDLE_CYC, go to ARB on the next cycle.
- ARB:
  - elig0 = req[0]. elig1 = req[1] AND (GATE_VBLANK==0 OR fval_s==0).
  - Both eligible: grant the requester the pointer selects, then set the pointer to the other requester.
  - Only one eligible: grant it and set the pointer to the other requester.
  - Neither eligible: stay in ARB.
  - If SCL or SDA goes low while in ARB (foreign activity), return to BUS_CHK with the counter cleared. Bus-low takes priority over a same-cycle grant.
  - A grant asserts gnt[n] on the cycle after the ARB decision and enters GRANT. The watchdog loads 0.
- GRANT(n):
  - The watchdog increments each cycle.
  - Release occurs on any of: done[n]=1, req[n]=0, or (TIMEOUT_CYC!=0 and watchdog==TIMEOUT_CYC-1).
  - On release, gnt goes to 00 on the next cycle and the block enters BUS_CHK with the idle counter 0. A grant therefore lasts exactly TIMEOUT_CYC cycles on timeout.
  - A timeout release also sets timeout_flag[n].
  - done or req changes from the non-granted requester are ignored. fval changes do not revoke an active grant.
- timeout_flag: cleared by timeout_clr. If a set and a clear occur in the same cycle, the set wins.
- Minimum gap between consecutive grants: 1 + BUS_IDLE_CYC cycles, assuming the bus is high.

Test Plan:
1. Reset release, bus high, req=01 held → gnt=01 no earlier than 2+BUS_IDLE_CYC+1 cycles after reset_n rises; scl_oe follows scl_oe_i[0] while granted.
2. req=11, fval=0 → gnt=01. Pulse done[0] → gnt=00 next cycle, then gnt=10 exactly BUS_IDLE_CYC+1 cycles later. Pulse done[1], req=11 again → gnt=01 (round-robin).
3. GATE_VBLANK=1, fval=1, req=10 → gnt stays 00 for 1000 cycles. Drop fval → gnt=10 within 2+1 cycles.
4. TIMEOUT_CYC=100, req=01 held, no done → gnt[0] high for exactly 100 cycles, then timeout_flag=01. Pulse timeout_clr → flag=00. Repeat with timeout_clr coincident with the expiry → flag=01.
5. sda_in held low externally while req=01 → no grant. Release sda_in → gnt=01 after 2+BUS_IDLE_CYC+1 cycles. A 1-cycle SDA glitch mid-count restarts the count.
6. Granted to 0 with scl_oe_i=01, assert reset_n=0 mid-grant → scl_oe=0 and gnt=00 without a clock edge; after release the flags are 00 and the pointer favours requester 0.

Source files
------------

// File: rtl/i2c_bus_arbiter.sv
// i2c_bus_arbiter: shares one open-drain I2C bus between two masters.
// Requester 0 is the Nios I2C core, requester 1 the auto-focus VCM writer.
// A grant is only issued after the bus has been seen idle (SCL and SDA
// both high) for BUS_IDLE_CYC consecutive synchronised cycles. Arbitration
// is round-robin. Requester 1 can be confined to vertical blanking. A
// watchdog forces release of a master that holds the bus too long.
//
// Handshake: req[n] is a level held for the whole transaction. gnt[n]
// (registered, one-hot) rises one cycle after the arbitration decision and
// is the only thing that lets that master's open-drain enables reach the
// pads. The grant ends on a done[n] pulse, on req[n] dropping, or on a
// watchdog expiry; gnt returns to 00 on the following cycle.
module i2c_bus_arbiter #(
  parameter int BUS_IDLE_CYC = 8,
  parameter int TIMEOUT_CYC  = 100000,
  parameter int WDOG_W       = 24,
  parameter bit GATE_VBLANK  = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic [1:0] done,
  output logic [1:0] gnt,
  input  logic [1:0] scl_oe_i,
  input  logic [1:0] sda_oe_i,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       scl_in,
  input  logic       sda_in,
  input  logic       fval,
  input  logic       timeout_clr,
  output logic [1:0] timeout_flag,
  output logic       busy
);

  localparam int CNT_W = (BUS_IDLE_CYC < 1) ? 1 : $clog2(BUS_IDLE_CYC + 1);
  localparam logic [CNT_W-1:0]  IDLE_LAST = CNT_W'(BUS_IDLE_CYC);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    ST_BUS_CHK = 2'd0,
    ST_ARB     = 2'd1,
    ST_GRANT   = 2'd2
  } state_t;

  // Synchroniser stages. Pads read as low until two clean samples arrive,
  // so the idle count after reset starts only once real levels are seen.
  logic              r_scl_meta, r_scl_s;
  logic              r_sda_meta, r_sda_s;
  logic              r_fval_meta, r_fval_s;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_idle_cnt, w_cnt_nxt;
  logic [WDOG_W-1:0] r_wdog, w_wdog_nxt;
  logic [1:0]        r_gnt, w_gnt_nxt;
  logic              r_ptr, w_ptr_nxt;
  logic [1:0]        r_flag, w_flag_nxt;
  logic [1:0]        w_flag_set;
  logic              w_win;

  logic              w_bus_high;
  logic [1:0]        w_elig;
  logic              w_gidx;
  logic              w_timeout;
  logic              w_release;
  logic [CNT_W-1:0]  w_cnt_inc;

  assign w_bus_high = r_scl_s & r_sda_s;
  assign w_elig     = {req[1] & ((GATE_VBLANK == 1'b0) | ~r_fval_s), req[0]};
  assign w_gidx     = r_gnt[1];
  assign w_timeout  = (TIMEOUT_CYC != 0) && (r_wdog == WDOG_LAST);
  assign w_release  = done[w_gidx] | ~req[w_gidx] | w_timeout;
  assign w_cnt_inc  = r_idle_cnt + CNT_W'(1);

  // Pad enables follow the granted master only; gated by the gnt register
  // so an async reset releases the pads without waiting for a clock.
  assign scl_oe       = |(r_gnt & scl_oe_i);
  assign sda_oe       = |(r_gnt & sda_oe_i);
  assign gnt          = r_gnt;
  assign busy         = |r_gnt;
  assign timeout_flag = r_flag;

  // Two-flop synchronisers for the asynchronous pad levels and FVAL.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_scl_meta  <= 1'b0;
      r_scl_s     <= 1'b0;
      r_sda_meta  <= 1'b0;
      r_sda_s     <= 1'b0;
      r_fval_meta <= 1'b0;
      r_fval_s    <= 1'b0;
    end else begin
      r_scl_meta  <= scl_in;
      r_scl_s     <= r_scl_meta;
      r_sda_meta  <= sda_in;
      r_sda_s     <= r_sda_meta;
      r_fval_meta <= fval;
      r_fval_s    <= r_fval_meta;
    end
  end

  // State register plus the counters, grant, pointer and flags it owns.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_BUS_CHK;
      r_idle_cnt <= '0;
      r_wdog     <= '0;
      r_gnt      <= 2'b00;
      r_ptr      <= 1'b0;
      r_flag     <= 2'b00;
    end else begin
      r_state    <= w_state_nxt;
      r_idle_cnt <= w_cnt_nxt;
      r_wdog     <= w_wdog_nxt;
      r_gnt      <= w_gnt_nxt;
      r_ptr      <= w_ptr_nxt;
      r_flag     <= w_flag_nxt;
    end
  end

  // Next-state logic: idle qualification, arbitration and grant release.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_idle_cnt;
    w_wdog_nxt  = r_wdog;
    w_gnt_nxt   = r_gnt;
    w_ptr_nxt   = r_ptr;
    w_flag_set  = 2'b00;
    w_win       = 1'b0;

    case (r_state)
      ST_BUS_CHK: begin
        // The cycle that completes the idle run also moves us to ARB.
        if (!w_bus_high) begin
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == IDLE_LAST) begin
            w_state_nxt = ST_ARB;
          end
        end
      end

      ST_ARB: begin
        // Foreign bus activity outranks any grant decided in the same cycle.
        if (!w_bus_high) begin
          w_state_nxt = ST_BUS_CHK;
          w_cnt_nxt   = '0;
        end else if (w_elig != 2'b00) begin
          w_win       = (w_elig == 2'b11) ? r_ptr : w_elig[1];
          w_gnt_nxt   = w_win ? 2'b10 : 2'b01;
          w_ptr_nxt   = ~w_win;
          w_wdog_nxt  = '0;
          w_state_nxt = ST_GRANT;
        end
      end

      ST_GRANT: begin
        w_wdog_nxt = r_wdog + WDOG_W'(1);
        if (w_release) begin
          w_gnt_nxt   = 2'b00;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_BUS_CHK;
          if (w_timeout) begin
            w_flag_set = r_gnt;
          end
        end
      end

      default: begin
        w_state_nxt = ST_BUS_CHK;
        w_gnt_nxt   = 2'b00;
        w_cnt_nxt   = '0;
      end
    endcase

    // A set in the same cycle as a clear wins.
    w_flag_nxt = (r_flag & ~{2{timeout_clr}}) | w_flag_set;
  end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Testbench for i2c_bus_arbiter: directed scenarios plus a randomized
// round-robin run checked against a transaction-level arbitration model.
module tb_i2c_bus_arbiter;

  localparam int IDLE = 8;
  localparam int TO   = 100;
  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] req = 2'b00;
  logic [1:0] done = 2'b00;
  logic [1:0] scl_oe_i = 2'b00;
  logic [1:0] sda_oe_i = 2'b00;
  logic       scl_in = 1'b1;
  logic       sda_in = 1'b1;
  logic       fval = 1'b0;
  logic       timeout_clr = 1'b0;
  logic [1:0] gnt;
  logic [1:0] timeout_flag;
  logic       scl_oe;
  logic       sda_oe;
  logic       busy;

  int n_cmp  = 0;
  int n_fail = 0;
  int last_win = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  i2c_bus_arbiter #(
    .BUS_IDLE_CYC(IDLE),
    .TIMEOUT_CYC (TO),
    .WDOG_W      (24),
    .GATE_VBLANK (1'b1)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (req),
    .done        (done),
    .gnt         (gnt),
    .scl_oe_i    (scl_oe_i),
    .sda_oe_i    (sda_oe_i),
    .scl_oe      (scl_oe),
    .sda_oe      (sda_oe),
    .scl_in      (scl_in),
    .sda_in      (sda_in),
    .fval        (fval),
    .timeout_clr (timeout_clr),
    .timeout_flag(timeout_flag),
    .busy        (busy)
  );

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, got hang required finish");
    $fatal(1, "global timeout");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Returns the number of edges until any grant appears, or -1 on expiry.
  task automatic wait_gnt(input int max_cyc, output int cyc);
    cyc = -1;
    for (int i = 1; i <= max_cyc; i++) begin
      tick();
      if (gnt != 2'b00) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic pulse_done(input logic [1:0] m);
    done = m;
    tick();
    done = 2'b00;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    scl_oe_i = 2'b11;
    sda_oe_i = 2'b11;
    #3;
    n_cmp++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b expected 00", gnt); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (timeout_flag !== 2'b00) begin n_fail++; $display("FAIL reset_flag: got %b expected 00", timeout_flag); end
    n_cmp++; if ({scl_oe, sda_oe} !== 2'b00) begin n_fail++; $display("FAIL reset_pads: got %b expected 00", {scl_oe, sda_oe}); end
    scl_oe_i = 2'b00;
    sda_oe_i = 2'b00;
    ticks(3);
  endtask

  task automatic test_first_grant();
    int c;
    req = 2'b01;
    @(negedge clk);
    reset_n = 1'b1;
    wait_gnt(40, c);
    n_cmp++;
    if (c < SYNC + IDLE + 1 || c > SYNC + IDLE + 3 || gnt !== 2'b01) begin
      n_fail++; $display("FAIL first_grant: got gnt=%b after %0d cycles expected 01 after >=%0d", gnt, c, SYNC + IDLE + 1);
    end
    last_win = 0;
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_granted: got %b expected 1", busy); end
    scl_oe_i = 2'b01; #1;
    n_cmp++; if (scl_oe !== 1'b1) begin n_fail++; $display("FAIL scl_mux_own: got %b expected 1", scl_oe); end
    scl_oe_i = 2'b10; #1;
    n_cmp++; if (scl_oe !== 1'b0) begin n_fail++; $display("FAIL scl_mux_other: got %b expected 0", scl_oe); end
    sda_oe_i = 2'b01; #1;
    n_cmp++; if (sda_oe !== 1'b1) begin n_fail++; $display("FAIL sda_mux_own: got %b expected 1", sda_oe); end
    sda_oe_i = 2'b10; #1;
    n_cmp++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL sda_mux_other: got %b expected 0", sda_oe); end
    scl_oe_i = 2'b00;
    sda_oe_i = 2'b00;
  endtask

  task automatic test_round_robin();
    req = 2'b11;
    fval = 1'b0;
    pulse_done(2'b01);
    n_cmp++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL rr_release0: got %b expected 00", gnt); end
    ticks(IDLE);
    n_cmp++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL rr_gap0: got %b expected 00", gnt); end
    tick();
    n_cmp++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL rr_grant1: got %b expected 10", gnt); end
    pulse_done(2'b10);
    n_cmp++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL rr_release1: got %b expected 00", gnt); end
    ticks(IDLE);
    n_cmp++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL rr_gap1: got %b expected 00", gnt); end
    tick();
    n_cmp++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL rr_grant0: got %b expected 01", gnt); end
    last_win = 0;
  endtask

  task automatic test_vblank();
    int nbad;
    int c;
    fval = 1'b1;
    req = 2'b10;
    tick();
    n_cmp++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL vb_req_drop: got %b expected 00", gnt); end
    nbad = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (gnt != 2'b00) nbad++;
    end
    n_cmp++; if (nbad != 0) begin n_fail++; $display("FAIL vb_blocked: got %0d granted cycles expected 0", nbad); end
    fval = 1'b0;
    wait_gnt(SYNC + 1, c);
    n_cmp++; if (c == -1 || gnt !== 2'b10) begin n_fail++; $display("FAIL vb_open: got gnt=%b after %0d expected 10 within %0d", gnt, c, SYNC + 1); end
    last_win = 1;
    pulse_done(2'b10);
    req = 2'b00;
    n_cmp++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL vb_release: got %b expected 00", gnt); end
  endtask

  task automatic test_timeout();
    int c;
    int n;
    req = 2'b01;
    wait_gnt(2 * IDLE + 10, c);
    n_cmp++; if (c == -1 || gnt !== 2'b01) begin n_fail++; $display("FAIL to_grant: got %b expected 01", gnt); end
    n = 0;
    for (int i = 0; i < TO + 20; i++) begin
      if (gnt[0] !== 1'b1) break;
      tick();
      n++;
    end
    n_cmp++; if (n != TO) begin n_fail++; $display("FAIL to_length: got %0d cycles expected %0d", n, TO); end
    n_cmp++; if (timeout_flag !== 2'b01) begin n_fail++; $display("FAIL to_flag_set: got %b expected 01", timeout_flag); end
    timeout_clr = 1'b1;
    tick();
    timeout_clr = 1'b0;
    n_cmp++; if (timeout_flag !== 2'b00) begin n_fail++; $display("FAIL to_flag_clr: got %b expected 00", timeout_flag); end
    wait_gnt(2 * IDLE + 10, c);
    n_cmp++; if (c == -1 || gnt !== 2'b01) begin n_fail++; $display("FAIL to_regrant: got %b expected 01", gnt); end
    ticks(TO - 1);
    timeout_clr = 1'b1;
    tick();
    timeout_clr = 1'b0;
    n_cmp++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL to_expire2: got %b expected 00", gnt); end
    n_cmp++; if (timeout_flag !== 2'b01) begin n_fail++; $display("FAIL to_set_wins: got %b expected 01", timeout_flag); end
    req = 2'b00;
    timeout_clr = 1'b1;
    tick();
    timeout_clr = 1'b0;
    last_win = 0;
  endtask

  task automatic test_bus_busy();
    int nbad;
    int c;
    sda_in = 1'b0;
    req = 2'b01;
    nbad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (gnt != 2'b00) nbad++;
    end
    n_cmp++; if (nbad != 0) begin n_fail++; $display("FAIL bb_held_low: got %0d granted cycles expected 0", nbad); end
    sda_in = 1'b1;
    wait_gnt(40, c);
    n_cmp++; if (c != SYNC + IDLE + 1 || gnt !== 2'b01) begin n_fail++; $display("FAIL bb_after_release: got gnt=%b after %0d expected 01 after %0d", gnt, c, SYNC + IDLE + 1); end
    pulse_done(2'b01);
    ticks(3);
    sda_in = 1'b0;
    tick();
    sda_in = 1'b1;
    wait_gnt(40, c);
    n_cmp++; if (c != SYNC + IDLE + 1 || gnt !== 2'b01) begin n_fail++; $display("FAIL bb_glitch_restart: got gnt=%b after %0d expected 01 after %0d", gnt, c, SYNC + IDLE + 1); end
    pulse_done(2'b01);
    req = 2'b00;
    last_win = 0;
  endtask

  task automatic test_arb_foreign();
    int c;
    ticks(IDLE + 5);
    scl_in = 1'b0;
    tick();
    scl_in = 1'b1;
    ticks(2);
    req = 2'b01;
    wait_gnt(40, c);
    n_cmp++; if (c != SYNC + IDLE + 1 - 2 || gnt !== 2'b01) begin n_fail++; $display("FAIL arb_foreign: got gnt=%b after %0d expected 01 after %0d", gnt, c, SYNC + IDLE - 1); end
    pulse_done(2'b01);
    n_cmp++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL arb_foreign_rel: got %b expected 00", gnt); end
    last_win = 0;
  endtask

  task automatic test_random_rr();
    logic [1:0] rq;
    logic       fv;
    logic       e0, e1;
    int         win;
    logic [1:0] mask;
    logic [1:0] other;
    int         h;
    for (int it = 0; it < 16; it++) begin
      rq = 2'($urandom_range(1, 3));
      fv = 1'($urandom_range(0, 1));
      if (fv && rq == 2'b10) rq = 2'b11;
      req = rq;
      fval = fv;
      scl_oe_i = 2'($urandom_range(0, 3));
      sda_oe_i = 2'($urandom_range(0, 3));
      e0 = rq[0];
      e1 = rq[1] && !fv;
      if (e0 && e1) win = 1 - last_win;
      else if (e0) win = 0;
      else win = 1;
      mask = (win == 1) ? 2'b10 : 2'b01;
      other = ~mask;
      ticks(IDLE);
      n_cmp++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL rnd_gap it%0d: got %b expected 00", it, gnt); end
      tick();
      n_cmp++; if (gnt !== mask) begin n_fail++; $display("FAIL rnd_grant it%0d: got %b expected %b", it, gnt, mask); end
      n_cmp++; if ({scl_oe, sda_oe} !== {scl_oe_i[win], sda_oe_i[win]}) begin n_fail++; $display("FAIL rnd_pads it%0d: got %b expected %b", it, {scl_oe, sda_oe}, {scl_oe_i[win], sda_oe_i[win]}); end
      last_win = win;
      h = $urandom_range(0, 6);
      for (int k = 0; k < h; k++) begin
        done = ($urandom_range(0, 1) == 1) ? other : 2'b00;
        fval = 1'($urandom_range(0, 1));
        tick();
        done = 2'b00;
      end
      n_cmp++; if (gnt !== mask) begin n_fail++; $display("FAIL rnd_hold it%0d: got %b expected %b", it, gnt, mask); end
      if ($urandom_range(0, 1) == 1) pulse_done(mask);
      else begin
        req = req & ~mask;
        tick();
      end
      n_cmp++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL rnd_release it%0d: got %b expected 00", it, gnt); end
    end
    req = 2'b00;
    fval = 1'b0;
    scl_oe_i = 2'b00;
    sda_oe_i = 2'b00;
  endtask

  task automatic test_reset_mid_grant();
    int c;
    req = 2'b10;
    fval = 1'b0;
    wait_gnt(2 * IDLE + 10, c);
    n_cmp++; if (c == -1 || gnt !== 2'b10) begin n_fail++; $display("FAIL rm_grant1: got %b expected 10", gnt); end
    ticks(TO);
    n_cmp++; if (gnt !== 2'b00 || timeout_flag !== 2'b10) begin n_fail++; $display("FAIL rm_timeout1: got gnt=%b flag=%b expected 00/10", gnt, timeout_flag); end
    req = 2'b01;
    wait_gnt(2 * IDLE + 10, c);
    n_cmp++; if (c == -1 || gnt !== 2'b01) begin n_fail++; $display("FAIL rm_grant0: got %b expected 01", gnt); end
    scl_oe_i = 2'b01;
    #1;
    n_cmp++; if (scl_oe !== 1'b1) begin n_fail++; $display("FAIL rm_pad_before: got %b expected 1", scl_oe); end
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++; if (scl_oe !== 1'b0) begin n_fail++; $display("FAIL rm_pad_async: got %b expected 0", scl_oe); end
    n_cmp++; if (gnt !== 2'b00 || busy !== 1'b0) begin n_fail++; $display("FAIL rm_gnt_async: got gnt=%b busy=%b expected 00/0", gnt, busy); end
    n_cmp++; if (timeout_flag !== 2'b00) begin n_fail++; $display("FAIL rm_flag_cleared: got %b expected 00", timeout_flag); end
    scl_oe_i = 2'b00;
    req = 2'b11;
    ticks(2);
    @(negedge clk);
    reset_n = 1'b1;
    wait_gnt(40, c);
    n_cmp++; if (c == -1 || gnt !== 2'b01) begin n_fail++; $display("FAIL rm_ptr_reset: got %b expected 01", gnt); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_first_grant();
    test_round_robin();
    test_vblank();
    test_timeout();
    test_bus_busy();
    test_arb_foreign();
    test_random_rr();
    test_reset_mid_grant();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
